// File: rtl/prio_enc_arb.sv
//------------------------------------------------------------------------------
// prio_enc_arb : registered N-way priority encoder / arbiter, fixed or
//                round-robin priority, result held on a valid/ready handshake.
// Optional macro PRIO_ENC_ARB_MASK_EN adds a req_mask input.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module prio_enc_arb #(
  parameter int N       = 8,
  parameter int RR_MODE = 0,
  parameter int W       = (N > 1) ? $clog2(N) : 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
`ifdef PRIO_ENC_ARB_MASK_EN
  input  logic [N-1:0] req_mask,
`endif
  input  logic         out_ready,
  output logic         out_valid,
  output logic [W-1:0] out_idx,
  output logic [N-1:0] out_onehot,
  output logic         busy
);

  localparam logic [0:0]   c_IDLE    = 1'b0;
  localparam logic [0:0]   c_HOLD    = 1'b1;
  localparam logic [W-1:0] c_PTR_TOP = W'(N - 1);
  localparam logic [N-1:0] c_ONE     = N'(1);

  logic [0:0]   r_state;
  logic         r_valid;
  logic [W-1:0] r_idx;
  logic [N-1:0] r_oh;

  logic [N-1:0] w_eff_req;
  logic         w_any;
  logic         w_handshake;
  logic [W-1:0] w_search_ptr;
  logic [W-1:0] w_win_idx;
  logic [N-1:0] w_win_oh;

  // Walk downward from p with wraparound; the first set bit wins.
  function automatic logic [W-1:0] f_search(input logic [N-1:0] r,
                                            input logic [W-1:0] p);
    logic [W-1:0] win;
    logic [W-1:0] jw;
    logic         found;
    int           j;
    win   = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      j = int'(p) - i;
      if (j < 0) j = j + N;
      jw = W'(j);
      if (!found && r[jw]) begin
        found = 1'b1;
        win   = jw;
      end
    end
    return win;
  endfunction

`ifdef PRIO_ENC_ARB_MASK_EN
  assign w_eff_req = req & ~req_mask;
`else
  assign w_eff_req = req;
`endif

  assign w_any       = |w_eff_req;
  assign w_handshake = r_valid & out_ready;
  assign w_win_idx   = f_search(w_eff_req, w_search_ptr);
  assign w_win_oh    = c_ONE << w_win_idx;

  generate
    if (RR_MODE != 0) begin : g_rr_ptr
      logic [W-1:0] r_ptr;
      logic [W-1:0] w_ptr_adv;

      // The granted requester drops to lowest priority once it is accepted.
      assign w_ptr_adv    = (r_idx == '0) ? c_PTR_TOP : r_idx - W'(1);
      assign w_search_ptr = w_handshake ? w_ptr_adv : r_ptr;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_ptr <= c_PTR_TOP;
        end else if (w_handshake) begin
          r_ptr <= w_ptr_adv;
        end
      end
    end else begin : g_fixed_ptr
      assign w_search_ptr = c_PTR_TOP;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_IDLE;
      r_valid <= 1'b0;
      r_idx   <= '0;
      r_oh    <= '0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (w_any) begin
            r_state <= c_HOLD;
            r_valid <= 1'b1;
            r_idx   <= w_win_idx;
            r_oh    <= w_win_oh;
          end
        end
        default: begin
          // Grant is frozen until taken; a new winner may load on the same edge.
          if (w_handshake) begin
            if (w_any) begin
              r_idx <= w_win_idx;
              r_oh  <= w_win_oh;
            end else begin
              r_state <= c_IDLE;
              r_valid <= 1'b0;
              r_idx   <= '0;
              r_oh    <= '0;
            end
          end
        end
      endcase
    end
  end

  assign out_valid  = r_valid;
  assign out_idx    = r_idx;
  assign out_onehot = r_oh;
  assign busy       = r_valid;

endmodule

`default_nettype wire

// File: tb/tb_prio_enc_arb.sv
//------------------------------------------------------------------------------
// tb_prio_enc_arb : self-checking bench for prio_enc_arb (N=4 fixed,
//                   N=4 round-robin, N=8 round-robin instances).
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_prio_enc_arb;

  logic clk;
  logic rst_n;

  logic [3:0] f_req, r_req;
  logic [7:0] q_req;
  logic       f_rdy, r_rdy, q_rdy;
  logic       f_valid, r_valid, q_valid;
  logic [1:0] f_idx, r_idx;
  logic [2:0] q_idx;
  logic [3:0] f_oh, r_oh;
  logic [7:0] q_oh;
  logic       f_busy, r_busy, q_busy;

`ifdef PRIO_ENC_ARB_MASK_EN
  logic [3:0] f_mask, r_mask;
  logic [7:0] q_mask;
  initial begin
    f_mask = '0;
    r_mask = '0;
    q_mask = '0;
  end
`endif

  prio_enc_arb #(.N(4), .RR_MODE(0)) u_fix4 (
    .clk(clk), .rst_n(rst_n), .req(f_req),
`ifdef PRIO_ENC_ARB_MASK_EN
    .req_mask(f_mask),
`endif
    .out_ready(f_rdy), .out_valid(f_valid), .out_idx(f_idx),
    .out_onehot(f_oh), .busy(f_busy)
  );

  prio_enc_arb #(.N(4), .RR_MODE(1)) u_rr4 (
    .clk(clk), .rst_n(rst_n), .req(r_req),
`ifdef PRIO_ENC_ARB_MASK_EN
    .req_mask(r_mask),
`endif
    .out_ready(r_rdy), .out_valid(r_valid), .out_idx(r_idx),
    .out_onehot(r_oh), .busy(r_busy)
  );

  prio_enc_arb #(.N(8), .RR_MODE(1)) u_rr8 (
    .clk(clk), .rst_n(rst_n), .req(q_req),
`ifdef PRIO_ENC_ARB_MASK_EN
    .req_mask(q_mask),
`endif
    .out_ready(q_rdy), .out_valid(q_valid), .out_idx(q_idx),
    .out_onehot(q_oh), .busy(q_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] req;
    logic [1:0] idx;
    logic [3:0] oh;
  } vec_t;

  typedef struct {
    string       name;
    logic        v;
    logic [31:0] idx;
    logic [31:0] oh;
  } exp_t;

  vec_t vecs[7];
  exp_t sb[$];
  int   n_tests;
  int   n_fail;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic av, input logic [31:0] ai,
                       input logic [31:0] ao, input logic ab, input logic ev,
                       input logic [31:0] ei, input logic [31:0] eo);
    n_tests++;
    if (av !== ev || ai !== ei || ao !== eo || ab !== ev) begin
      n_fail++;
      $display("FAIL %s: got valid=%0b idx=%0d onehot=%0h busy=%0b, expected valid=%0b idx=%0d onehot=%0h busy=%0b",
               nm, av, ai, ao, ab, ev, ei, eo, ev);
    end
  endtask

  task automatic sb_push(input string nm, input logic v, input int idx, input int oh);
    exp_t e;
    e.name = nm;
    e.v    = v;
    e.idx  = 32'(idx);
    e.oh   = 32'(oh);
    sb.push_back(e);
  endtask

  task automatic sb_pop(input int sel);
    exp_t e;
    if (sb.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard_empty: got no entry, expected one pending result");
    end else begin
      e = sb.pop_front();
      case (sel)
        0:       check(e.name, f_valid, 32'(f_idx), 32'(f_oh), f_busy, e.v, e.idx, e.oh);
        1:       check(e.name, r_valid, 32'(r_idx), 32'(r_oh), r_busy, e.v, e.idx, e.oh);
        default: check(e.name, q_valid, 32'(q_idx), 32'(q_oh), q_busy, e.v, e.idx, e.oh);
      endcase
    end
  endtask

  task automatic cyc_expect(input int sel, input string nm, input logic v,
                            input int idx, input int oh);
    sb_push(nm, v, idx, oh);
    step();
    sb_pop(sel);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no completion, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;
    vecs[0] = '{4'b0001, 2'd0, 4'b0001};
    vecs[1] = '{4'b0010, 2'd1, 4'b0010};
    vecs[2] = '{4'b0100, 2'd2, 4'b0100};
    vecs[3] = '{4'b1000, 2'd3, 4'b1000};
    vecs[4] = '{4'b0110, 2'd2, 4'b0100};
    vecs[5] = '{4'b1010, 2'd3, 4'b1000};
    vecs[6] = '{4'b1100, 2'd3, 4'b1000};

    rst_n = 1'b0;
    f_req = '0; r_req = '0; q_req = '0;
    f_rdy = 1'b1; r_rdy = 1'b1; q_rdy = 1'b1;
    #2;
    sb_push("rst_fix4", 1'b0, 0, 0); sb_pop(0);
    sb_push("rst_rr4",  1'b0, 0, 0); sb_pop(1);
    sb_push("rst_rr8",  1'b0, 0, 0); sb_pop(2);
    step();
    step();
    rst_n = 1'b1;

    // Idle with no requests
    for (int i = 0; i < 5; i++) cyc_expect(0, "t1_idle", 1'b0, 0, 0);

    // Fixed-priority table, each request held two cycles
    for (int v = 0; v < 7; v++) begin
      for (int k = 0; k < 2; k++) begin
        f_req = vecs[v].req;
        cyc_expect(0, $sformatf("t2_vec%0d", v), 1'b1, int'(vecs[v].idx), int'(vecs[v].oh));
      end
    end
    f_req = '0;
    cyc_expect(0, "t2_to_idle", 1'b0, 0, 0);

    // Hold under back-pressure while requests drop
    f_rdy = 1'b0;
    f_req = 4'b1010;
    cyc_expect(0, "t3_hold0", 1'b1, 3, 8);
    f_req = 4'b0000;
    for (int i = 1; i < 4; i++) cyc_expect(0, $sformatf("t3_hold%0d", i), 1'b1, 3, 8);
    f_rdy = 1'b1;
    cyc_expect(0, "t3_taken", 1'b0, 0, 0);

    // Round-robin rotation on N=4
    r_req = 4'b1111;
    cyc_expect(1, "t4_g0", 1'b1, 3, 8);
    cyc_expect(1, "t4_g1", 1'b1, 2, 4);
    cyc_expect(1, "t4_g2", 1'b1, 1, 2);
    cyc_expect(1, "t4_g3", 1'b1, 0, 1);
    cyc_expect(1, "t4_g4", 1'b1, 3, 8);
    r_req = '0;
    cyc_expect(1, "t4_idle", 1'b0, 0, 0);

    // Round-robin pointer after accepting idx 5 on N=8
    q_rdy = 1'b0;
    q_req = 8'b0010_0000;
    cyc_expect(2, "t5_g5", 1'b1, 5, 8'h20);
    q_rdy = 1'b1;
    q_req = 8'b1010_0001;
    cyc_expect(2, "t5_g0", 1'b1, 0, 8'h01);
    cyc_expect(2, "t5_g7", 1'b1, 7, 8'h80);
    q_req = '0;
    cyc_expect(2, "t5_idle", 1'b0, 0, 0);

    // Asynchronous reset in HOLD, then pointer restored to N-1
    r_rdy = 1'b0;
    r_req = 4'b0100;
    cyc_expect(1, "t6_hold2", 1'b1, 2, 4);
    #2;
    rst_n = 1'b0;
    #1;
    sb_push("t6_async_rst", 1'b0, 0, 0);
    sb_pop(1);
    step();
    rst_n = 1'b1;
    r_req = 4'b1001;
    r_rdy = 1'b1;
    cyc_expect(1, "t6_ptr_top", 1'b1, 3, 8);
    r_req = 4'b0100;
    cyc_expect(1, "t6_g2", 1'b1, 2, 4);
    r_req = '0;
    cyc_expect(1, "t6_idle", 1'b0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
